// File: rtl/axis_packet_fifo.sv
// Store-and-forward AXI-Stream FIFO: a packet is presented on the output only once its tlast beat
// is stored. If one packet alone fills the storage, that packet is passed through cut-through.
module axis_packet_fifo #(
  parameter int unsigned AXIS_BYTES     = 1,
  parameter int unsigned AXIS_USER_BITS = 1,
  parameter int unsigned DEPTH          = 64
) (
  input  logic                      clk,
  input  logic                      sreset,
  input  logic [AXIS_BYTES*8-1:0]   axis_i_tdata,
  input  logic [AXIS_USER_BITS-1:0] axis_i_tuser,
  input  logic                      axis_i_tlast,
  input  logic                      axis_i_tvalid,
  output logic                      axis_i_tready,
  output logic [AXIS_BYTES*8-1:0]   axis_o_tdata,
  output logic [AXIS_USER_BITS-1:0] axis_o_tuser,
  output logic                      axis_o_tlast,
  output logic                      axis_o_tvalid,
  input  logic                      axis_o_tready,
  output logic [$clog2(DEPTH):0]    level,
  output logic [$clog2(DEPTH):0]    pkt_count
);

  localparam int unsigned DataW  = AXIS_BYTES * 8;
  localparam int unsigned EntryW = DataW + AXIS_USER_BITS + 1;
  localparam int unsigned PtrW   = $clog2(DEPTH);
  localparam int unsigned CntW   = PtrW + 1;
  localparam logic [CntW-1:0] Full = CntW'(DEPTH);

  logic [EntryW-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]   level_q, level_d, pkt_q, pkt_d;
  logic              partial_q, partial_d;
  logic              wr_open_q, wr_open_d;
  logic              wr_en, rd_en, wr_last, rd_last, pkt_inc, pkt_dec;
  logic [EntryW-1:0] rd_entry;

  assign axis_i_tready = (level_q != Full);
  assign axis_o_tvalid = (level_q != '0) && ((pkt_q != '0) || partial_q);

  assign rd_entry = mem_q[rd_ptr_q];
  assign {axis_o_tlast, axis_o_tuser, axis_o_tdata} = rd_entry;

  assign wr_en   = axis_i_tvalid && axis_i_tready;
  assign rd_en   = axis_o_tvalid && axis_o_tready;
  assign wr_last = wr_en && axis_i_tlast;
  assign rd_last = rd_en && axis_o_tlast;

  // The oversize packet's own tlast is never counted on either side.
  assign pkt_inc = wr_last && !wr_open_q;
  assign pkt_dec = rd_last && !partial_q;

  assign level     = level_q;
  assign pkt_count = pkt_q;

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    level_d   = level_q;
    pkt_d     = pkt_q;
    partial_d = partial_q;
    wr_open_d = wr_open_q;

    if (wr_en) wr_ptr_d = wr_ptr_q + 1'b1;
    if (rd_en) rd_ptr_d = rd_ptr_q + 1'b1;

    unique case ({wr_en, rd_en})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase

    unique case ({pkt_inc, pkt_dec})
      2'b10:   pkt_d = pkt_q + 1'b1;
      2'b01:   pkt_d = pkt_q - 1'b1;
      default: pkt_d = pkt_q;
    endcase

    // Storage full with no complete packet: the packet being written is oversize.
    if (partial_q && rd_last) begin
      partial_d = 1'b0;
    end else if (!partial_q && (level_q == Full) && (pkt_q == '0)) begin
      partial_d = 1'b1;
      wr_open_d = 1'b1;
    end
    if (wr_open_q && wr_last) wr_open_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (sreset) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      level_q   <= '0;
      pkt_q     <= '0;
      partial_q <= 1'b0;
      wr_open_q <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      level_q   <= level_d;
      pkt_q     <= pkt_d;
      partial_q <= partial_d;
      wr_open_q <= wr_open_d;
    end
  end

  // Storage array carries no reset so it maps onto a plain dual-port RAM.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= {axis_i_tlast, axis_i_tuser, axis_i_tdata};
  end

endmodule

// File: tb/tb_axis_packet_fifo.sv
// Bench for axis_packet_fifo: directed vector table on a DEPTH=8 instance, an oversize-packet
// sequence, and randomized traffic on DEPTH=8 and DEPTH=64 instances against a queue model.
module tb_axis_packet_fifo;

  logic       clk;
  logic       sreset;
  logic [7:0] i_tdata;
  logic       i_tuser, i_tlast, i_tvalid, o_tready;
  logic       sel;

  logic [7:0] odata8, odata64;
  logic       ouser8, ouser64, olast8, olast64, ovld8, ovld64, irdy8, irdy64;
  logic [3:0] lvl8, pkt8;
  logic [6:0] lvl64, pkt64;

  logic [7:0] odata;
  logic       ouser, olast, ovld, irdy;
  logic [6:0] lvl, pkt;

  int checks;
  int failures;

  typedef struct packed {
    logic       last;
    logic       user;
    logic [7:0] data;
  } beat_t;

  typedef struct {
    bit         rst;
    bit         vld;
    logic [7:0] d;
    bit         l;
    bit         ordy;
    bit         chk;
    bit         e_irdy;
    bit         e_ovld;
    bit         chk_d;
    logic [7:0] e_d;
    bit         e_l;
    int         e_lvl;
    int         e_pkt;
  } vec_t;

  vec_t vecs[$];

  axis_packet_fifo #(
    .AXIS_BYTES(1), .AXIS_USER_BITS(1), .DEPTH(8)
  ) u_dut8 (
    .clk(clk), .sreset(sreset),
    .axis_i_tdata(i_tdata), .axis_i_tuser(i_tuser), .axis_i_tlast(i_tlast),
    .axis_i_tvalid(i_tvalid), .axis_i_tready(irdy8),
    .axis_o_tdata(odata8), .axis_o_tuser(ouser8), .axis_o_tlast(olast8),
    .axis_o_tvalid(ovld8), .axis_o_tready(o_tready && !sel),
    .level(lvl8), .pkt_count(pkt8)
  );

  axis_packet_fifo #(
    .AXIS_BYTES(1), .AXIS_USER_BITS(1), .DEPTH(64)
  ) u_dut64 (
    .clk(clk), .sreset(sreset),
    .axis_i_tdata(i_tdata), .axis_i_tuser(i_tuser), .axis_i_tlast(i_tlast),
    .axis_i_tvalid(i_tvalid), .axis_i_tready(irdy64),
    .axis_o_tdata(odata64), .axis_o_tuser(ouser64), .axis_o_tlast(olast64),
    .axis_o_tvalid(ovld64), .axis_o_tready(o_tready && sel),
    .level(lvl64), .pkt_count(pkt64)
  );

  assign odata = sel ? odata64 : odata8;
  assign ouser = sel ? ouser64 : ouser8;
  assign olast = sel ? olast64 : olast8;
  assign ovld  = sel ? ovld64 : ovld8;
  assign irdy  = sel ? irdy64 : irdy8;
  assign lvl   = sel ? lvl64 : {3'b000, lvl8};
  assign pkt   = sel ? pkt64 : {3'b000, pkt8};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp,
               $time);
    end
  endtask

  task automatic add(input bit rst, input bit vld, input logic [7:0] d, input bit l,
                     input bit ordy, input bit chk, input bit e_irdy, input bit e_ovld,
                     input bit chk_d, input logic [7:0] e_d, input bit e_l, input int e_lvl,
                     input int e_pkt);
    vec_t v;
    v.rst = rst; v.vld = vld; v.d = d; v.l = l; v.ordy = ordy; v.chk = chk;
    v.e_irdy = e_irdy; v.e_ovld = e_ovld; v.chk_d = chk_d; v.e_d = e_d; v.e_l = e_l;
    v.e_lvl = e_lvl; v.e_pkt = e_pkt;
    vecs.push_back(v);
  endtask

  task automatic idle_inputs();
    i_tvalid = 1'b0; i_tdata = 8'h00; i_tuser = 1'b0; i_tlast = 1'b0; o_tready = 1'b0;
  endtask

  task automatic reset_dut();
    idle_inputs();
    sreset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    sreset = 1'b0;
    check("rst_irdy", int'(irdy), 1);
    check("rst_ovld", int'(ovld), 0);
    check("rst_level", int'(lvl), 0);
    check("rst_pkt", int'(pkt), 0);
  endtask

  task automatic run_table();
    foreach (vecs[i]) begin
      sreset   = vecs[i].rst;
      i_tvalid = vecs[i].vld;
      i_tdata  = vecs[i].d;
      i_tuser  = vecs[i].d[0];
      i_tlast  = vecs[i].l;
      o_tready = vecs[i].ordy;
      if (vecs[i].chk) begin
        check($sformatf("vec%0d_irdy", i), int'(irdy), int'(vecs[i].e_irdy));
        check($sformatf("vec%0d_ovld", i), int'(ovld), int'(vecs[i].e_ovld));
        check($sformatf("vec%0d_level", i), int'(lvl), vecs[i].e_lvl);
        check($sformatf("vec%0d_pkt", i), int'(pkt), vecs[i].e_pkt);
        if (vecs[i].chk_d) begin
          check($sformatf("vec%0d_data", i), int'(odata), int'(vecs[i].e_d));
          check($sformatf("vec%0d_user", i), int'(ouser), int'(vecs[i].e_d[0]));
          check($sformatf("vec%0d_last", i), int'(olast), int'(vecs[i].e_l));
        end
      end
      @(negedge clk);
    end
    sreset = 1'b0;
    idle_inputs();
  endtask

  // One 12-beat packet through the DEPTH=8 instance with the sink always ready.
  task automatic run_oversize();
    int  sent, got, max_pkt;
    bit  saw_full;
    sel = 1'b0;
    reset_dut();
    sent = 0; got = 0; max_pkt = 0; saw_full = 1'b0;
    o_tready = 1'b1;
    for (int c = 0; c < 200 && got < 12; c++) begin
      i_tvalid = (sent < 12);
      i_tdata  = 8'(8'h40 + sent);
      i_tuser  = 1'b0;
      i_tlast  = (sent == 11);
      if (int'(lvl) == 8 && int'(pkt) == 0) saw_full = 1'b1;
      if (int'(pkt) > max_pkt) max_pkt = int'(pkt);
      if (ovld) begin
        check("ovs_data", int'(odata), 8'h40 + got);
        check("ovs_last", int'(olast), int'(got == 11));
      end
      if (i_tvalid && irdy) sent++;
      if (ovld && o_tready) got++;
      @(negedge clk);
    end
    idle_inputs();
    check("ovs_beats", got, 12);
    check("ovs_saw_full", int'(saw_full), 1);
    check("ovs_max_pkt", max_pkt, 0);
    check("ovs_end_level", int'(lvl), 0);
    check("ovs_end_pkt", int'(pkt), 0);
    check("ovs_end_ovld", int'(ovld), 0);
  endtask

  // Random traffic against a queue model of stored beats.
  task automatic run_random(input bit use64, input int npkts, input int maxlen);
    beat_t q[$];
    beat_t cb, f;
    int    depth, tl, sent_pkts, got_pkts, left, pre_size, pre_tl, exp_pkt;
    bit    cur, mpart, wr, rd, popped_last;
    depth = use64 ? 64 : 8;
    sel = use64;
    reset_dut();
    q.delete();
    tl = 0; sent_pkts = 0; got_pkts = 0; left = 0; cur = 1'b0; mpart = 1'b0;
    cb = '0;
    for (int c = 0; c < 45000 && got_pkts < npkts; c++) begin
      if (!cur && sent_pkts < npkts && $urandom_range(0, 1) == 1) begin
        if (left == 0) left = $urandom_range(maxlen, 1);
        cb.data = 8'($urandom);
        cb.user = 1'($urandom);
        cb.last = (left == 1);
        cur = 1'b1;
      end
      i_tvalid = cur;
      i_tdata  = cb.data;
      i_tuser  = cb.user;
      i_tlast  = cb.last;
      o_tready = ($urandom_range(0, 1) == 1);

      // A complete packet stored always shows valid; the oversize packet's tlast is uncounted.
      exp_pkt = tl - ((mpart && tl > 0) ? 1 : 0);
      check("rnd_level", int'(lvl), q.size());
      check("rnd_pkt", int'(pkt), exp_pkt);
      check("rnd_irdy", int'(irdy), int'(q.size() != depth));
      check("rnd_ovld", int'(ovld), int'(tl > 0 || (q.size() > 0 && mpart)));
      if (ovld && q.size() > 0) check("rnd_beat", int'({olast, ouser, odata}), int'(q[0]));

      wr = cur && irdy;
      rd = ovld && o_tready && (q.size() > 0);
      pre_size = q.size();
      pre_tl = tl;
      popped_last = 1'b0;
      if (rd) begin
        f = q.pop_front();
        if (f.last) begin
          tl--;
          got_pkts++;
          popped_last = 1'b1;
        end
      end
      if (mpart && popped_last) mpart = 1'b0;
      else if (pre_size == depth && pre_tl == 0) mpart = 1'b1;
      if (wr) begin
        q.push_back(cb);
        if (cb.last) begin
          tl++;
          sent_pkts++;
        end
        left--;
        cur = 1'b0;
      end
      @(negedge clk);
    end
    idle_inputs();
    check(use64 ? "rnd64_pkts" : "rnd8_pkts", got_pkts, npkts);
    check(use64 ? "rnd64_empty" : "rnd8_empty", q.size(), 0);
  endtask

  initial begin
    checks = 0;
    failures = 0;
    sel = 1'b0;
    idle_inputs();
    sreset = 1'b1;

    // rst vld d l ordy | chk irdy ovld chk_d e_d e_l lvl pkt
    add(0, 1, 8'h11, 0, 1, 1, 1, 0, 0, 8'h00, 0, 0, 0);
    add(0, 1, 8'h22, 0, 1, 1, 1, 0, 0, 8'h00, 0, 1, 0);
    add(0, 1, 8'h33, 1, 1, 1, 1, 0, 0, 8'h00, 0, 2, 0);
    add(0, 0, 8'h00, 0, 1, 1, 1, 1, 1, 8'h11, 0, 3, 1);
    add(0, 0, 8'h00, 0, 1, 1, 1, 1, 1, 8'h22, 0, 2, 1);
    add(0, 0, 8'h00, 0, 1, 1, 1, 1, 1, 8'h33, 1, 1, 1);
    add(0, 0, 8'h00, 0, 1, 1, 1, 0, 0, 8'h00, 0, 0, 0);
    for (int k = 0; k < 8; k++) begin
      add(0, 1, (k < 4) ? 8'(8'hA0 + k) : 8'(8'hB0 + k - 4), (k == 3 || k == 7), 0,
          1, 1, (k >= 4), (k >= 4), 8'hA0, 0, k, (k >= 4) ? 1 : 0);
    end
    add(0, 1, 8'hEE, 1, 1, 1, 0, 1, 1, 8'hA0, 0, 8, 2);
    add(0, 0, 8'h00, 0, 0, 1, 1, 1, 1, 8'hA1, 0, 7, 2);
    add(1, 0, 8'h00, 0, 0, 0, 0, 0, 0, 8'h00, 0, 0, 0);
    add(0, 1, 8'hC5, 1, 0, 1, 1, 0, 0, 8'h00, 0, 0, 0);
    add(0, 1, 8'hD6, 1, 1, 1, 1, 1, 1, 8'hC5, 1, 1, 1);
    add(0, 0, 8'h00, 0, 0, 1, 1, 1, 1, 8'hD6, 1, 1, 1);
    add(1, 0, 8'h00, 0, 0, 0, 0, 0, 0, 8'h00, 0, 0, 0);
    add(0, 1, 8'h01, 0, 1, 1, 1, 0, 0, 8'h00, 0, 0, 0);
    add(0, 1, 8'h02, 0, 1, 1, 1, 0, 0, 8'h00, 0, 1, 0);
    add(1, 0, 8'h00, 0, 1, 1, 1, 0, 0, 8'h00, 0, 2, 0);
    add(0, 0, 8'h00, 0, 1, 1, 1, 0, 0, 8'h00, 0, 0, 0);
    add(0, 1, 8'hAB, 1, 1, 1, 1, 0, 0, 8'h00, 0, 0, 0);
    add(0, 0, 8'h00, 0, 1, 1, 1, 1, 1, 8'hAB, 1, 1, 1);
    add(0, 0, 8'h00, 0, 1, 1, 1, 0, 0, 8'h00, 0, 0, 0);

    @(negedge clk);
    reset_dut();
    run_table();
    run_oversize();
    run_random(1'b0, 150, 12);
    run_random(1'b1, 1000, 20);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
